// File: rtl/nap_pkg.sv
// Shared types and width helpers for the nap timer.
package nap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NAPPING,
        RING,
        STOPPING,
        SNOOZE
    } state_e;

    localparam int unsigned TICK_DIV_DEF = 1000;
    localparam int unsigned RING_MAX_DEF = 60;
    localparam int unsigned TICK_W       = $clog2(TICK_DIV_DEF);
    localparam int unsigned RING_W       = $clog2(RING_MAX_DEF + 1);

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nap_timer_btn_debounce.sv
// Button synchronizer, stability debouncer and rising-edge press detector.
module btn_debounce
    import nap_pkg::*;
#(
    parameter int unsigned DEB_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned DW = cnt_w(DEB_LEN);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [DW-1:0] cnt_q, cnt_d;

    // A level change is taken only after DEB_LEN consecutive disagreeing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DW'(DEB_LEN - 1)) level_d = sync2_q;
            else cnt_d = cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign press = level_q & ~prev_q;

endmodule

// File: rtl/nap_timer.sv
// Nap countdown controller driving alarm start/stop pulses.
// Optional snooze support is compiled in with SNOOZE_EN.
module nap_timer
    import nap_pkg::*;
#(
    parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
    parameter int unsigned NAP_W         = 12,
    parameter int unsigned DEFAULT_TICKS = 600,
    parameter int unsigned RING_MAX      = RING_MAX_DEF,
    parameter int unsigned DEB_LEN       = 4,
    parameter int unsigned SNOOZE_TICKS  = 300,
    parameter int unsigned SNOOZE_MAX    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_valid,
    input  logic [NAP_W-1:0] set_ticks,
    input  logic             go,
    input  logic             btn,
    output logic             start,
    output logic             stop,
    output logic             busy,
    output logic             ringing,
    output logic [NAP_W-1:0] remaining
);

    localparam int unsigned TW =
        (TICK_DIV > TICK_DIV_DEF) ? cnt_w(TICK_DIV) : TICK_W;
    localparam int unsigned RW =
        (RING_MAX > RING_MAX_DEF) ? cnt_w(RING_MAX + 1) : RING_W;

    state_e           state_q, state_d;
    logic [NAP_W-1:0] dur_q, dur_d;
    logic [NAP_W-1:0] rem_q, rem_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [RW-1:0]    ring_q, ring_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             press, tick, load, expire, timeout;

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
        .clock (clock),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );

    assign tick    = (tick_q == TW'(TICK_DIV - 1));
    assign load    = set_valid && (set_ticks != '0);
    assign expire  = tick && (rem_q == NAP_W'(1));
    assign timeout = (ring_q == RW'(RING_MAX));

`ifdef SNOOZE_EN
    localparam int unsigned SW = cnt_w(SNOOZE_MAX + 1);
    logic [SW-1:0] snz_q, snz_d;
`else
    logic unused_snooze;
    assign unused_snooze = ^{SNOOZE_TICKS, SNOOZE_MAX};
`endif

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        rem_d   = rem_q;
        ring_d  = ring_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        tick_d  = tick ? '0 : tick_q + TW'(1);
`ifdef SNOOZE_EN
        snz_d   = snz_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef SNOOZE_EN
                snz_d = '0;
`endif
                if (load) dur_d = set_ticks;
                if (go) begin
                    state_d = NAPPING;
                    rem_d   = load ? set_ticks : dur_q;
                    tick_d  = '0;
                end
            end
            NAPPING: begin
                if (press) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (expire) begin
                    state_d = RING;
                    rem_d   = '0;
                    ring_d  = '0;
                    tick_d  = '0;
                    start_d = 1'b1;
                end else if (tick && rem_q != '0) begin
                    rem_d = rem_q - NAP_W'(1);
                end
            end
            RING: begin
                if (tick) ring_d = ring_q + RW'(1);
                if (press || timeout) begin
                    stop_d  = 1'b1;
                    state_d = STOPPING;
`ifdef SNOOZE_EN
                    // Only a press (never a timeout) may snooze.
                    if (press && !timeout && snz_q < SW'(SNOOZE_MAX)) begin
                        state_d = SNOOZE;
                        rem_d   = NAP_W'(SNOOZE_TICKS);
                        snz_d   = snz_q + SW'(1);
                        tick_d  = '0;
                    end
`endif
                end
            end
            STOPPING: begin
                state_d = IDLE;
            end
`ifdef SNOOZE_EN
            SNOOZE: begin
                if (press) begin
                    state_d = STOPPING;
                    stop_d  = 1'b1;
                    rem_d   = '0;
                end else if (expire) begin
                    state_d = RING;
                    rem_d   = '0;
                    ring_d  = '0;
                    tick_d  = '0;
                    start_d = 1'b1;
                end else if (tick && rem_q != '0) begin
                    rem_d = rem_q - NAP_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dur_q   <= NAP_W'(DEFAULT_TICKS);
            rem_q   <= '0;
            tick_q  <= '0;
            ring_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
`ifdef SNOOZE_EN
            snz_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            ring_q  <= ring_d;
            start_q <= start_d;
            stop_q  <= stop_d;
`ifdef SNOOZE_EN
            snz_q   <= snz_d;
`endif
        end
    end

    assign start     = start_q;
    assign stop      = stop_q;
    assign busy      = (state_q != IDLE);
    assign ringing   = (state_q == RING);
    assign remaining = rem_q;

endmodule

// File: tb/tb_nap_timer.sv
// Directed bench for nap_timer with TICK_DIV=4, RING_MAX=5, DEB_LEN=4.
module tb_nap_timer;

    logic        clock = 1'b0;
    logic        reset;
    logic        set_valid;
    logic [11:0] set_ticks;
    logic        go;
    logic        btn;
    logic        start, stop, busy, ringing;
    logic [11:0] remaining;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    nap_timer #(
        .TICK_DIV     (4),
        .NAP_W        (12),
        .DEFAULT_TICKS(600),
        .RING_MAX     (5),
        .DEB_LEN      (4),
        .SNOOZE_TICKS (2),
        .SNOOZE_MAX   (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .set_valid(set_valid),
        .set_ticks(set_ticks),
        .go       (go),
        .btn      (btn),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .ringing  (ringing),
        .remaining(remaining)
    );

    typedef struct {
        logic        sv;
        logic [11:0] st;
        logic        g;
        logic        e_busy;
        logic        e_ring;
        logic        e_start;
        logic        e_stop;
        logic [11:0] e_rem;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic sv, input int st, input logic g,
                                input logic b, input logic r, input logic s,
                                input logic p, input int rem);
        vec_t v;
        v.sv = sv; v.st = 12'(st); v.g = g;
        v.e_busy = b; v.e_ring = r; v.e_start = s; v.e_stop = p;
        v.e_rem = 12'(rem);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; set_valid = 1'b0; set_ticks = '0; go = 1'b0; btn = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input bit want_stop, input int max,
                              output int n, output int other);
        bit hit;
        n = 0; other = 0; hit = 1'b0;
        while (!hit && n < max) begin
            step();
            n++;
            hit = want_stop ? stop : start;
            if ((want_stop ? start : stop) == 1'b1) other++;
        end
        if (!hit) n = -1;
    endtask

    task automatic run_quiet(input int k, output int pulses);
        pulses = 0;
        for (int i = 0; i < k; i++) begin
            step();
            if (start || stop) pulses++;
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            n_cmp++;
            if (start === 1'b1 && stop === 1'b1) begin
                n_bad++;
                $display("FAIL start_stop_overlap: got both high, expected exclusive");
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n, other, pulses;

        tbl[0]  = mk(1, 3, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 0, 0, 0, 3);
        tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 3);
        tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, 3);
        tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0, 3);
        tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0, 2);
        tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 2);
        tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 2);
        tbl[8]  = mk(0, 0, 0, 1, 0, 0, 0, 2);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 1, 1, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 1, 1, 0, 0, 0);

        do_reset();
        chk("rst.start", start, 0);
        chk("rst.stop", stop, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ringing", ringing, 0);
        chk("rst.remaining", remaining, 0);

        // nap of 3 ticks: start 12 edges after go
        for (int i = 0; i < 15; i++) begin
            set_valid = tbl[i].sv; set_ticks = tbl[i].st; go = tbl[i].g;
            step();
            chk($sformatf("v%0d.busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d.ringing", i), ringing, tbl[i].e_ring);
            chk($sformatf("v%0d.start", i), start, tbl[i].e_start);
            chk($sformatf("v%0d.stop", i), stop, tbl[i].e_stop);
            chk($sformatf("v%0d.remaining", i), remaining, tbl[i].e_rem);
        end
        set_valid = 0; set_ticks = '0; go = 0;

        // ring timeout: stop 21 edges after start edge
        wait_pulse(1, 40, n, other);
        chk("timeout.lat", n, 20);
        chk("timeout.start", other, 0);
        chk("timeout.ringing", ringing, 0);
        chk("timeout.busy", busy, 1);
        step();
        chk("timeout.idle", busy, 0);
        chk("timeout.stop_once", stop, 0);

        // set+go together, then debounce glitch and real press in RING
        set_valid = 1; set_ticks = 1; go = 1;
        step();
        set_valid = 0; go = 0;
        chk("setgo.remaining", remaining, 1);
        wait_pulse(0, 10, n, other);
        chk("setgo.lat", n, 4);
        btn = 1;
        step(); step();
        btn = 0;
        run_quiet(8, pulses);
        chk("glitch.pulses", pulses, 0);
        chk("glitch.ringing", ringing, 1);
        btn = 1;
        wait_pulse(1, 12, n, other);
        chk("press.lat", n, 7);
        chk("press.start", other, 0);
        run_quiet(6, pulses);
        chk("hold.pulses", pulses, 0);
`ifdef SNOOZE_EN
        chk("hold.busy", busy, 1);
`else
        chk("hold.busy", busy, 0);
`endif
        btn = 0;
        do_reset();

        // press during NAPPING while remaining is 2
        set_valid = 1; set_ticks = 3; go = 1;
        step();
        set_valid = 0; go = 0; btn = 1;
        run_quiet(6, pulses);
        chk("cancel.pre_pulses", pulses, 0);
        chk("cancel.pre_busy", busy, 1);
        chk("cancel.pre_rem", remaining, 2);
        step();
        chk("cancel.busy", busy, 0);
        chk("cancel.remaining", remaining, 0);
        run_quiet(16, pulses);
        chk("cancel.pulses", pulses, 0);
        btn = 0;
        do_reset();

        // reset mid-RING aborts silently, duration back to default
        set_valid = 1; set_ticks = 1; go = 1;
        step();
        set_valid = 0; go = 0;
        wait_pulse(0, 10, n, other);
        chk("abort.lat", n, 4);
        step(); step(); step();
        reset = 1;
        step();
        reset = 0;
        chk("abort.start", start, 0);
        chk("abort.stop", stop, 0);
        chk("abort.busy", busy, 0);
        chk("abort.ringing", ringing, 0);
        chk("abort.remaining", remaining, 0);
        run_quiet(10, pulses);
        chk("abort.pulses", pulses, 0);
        go = 1;
        step();
        go = 0;
        chk("dflt.remaining", remaining, 600);
        wait_pulse(0, 2500, n, other);
        chk("dflt.lat", n, 2400);
        wait_pulse(1, 30, n, other);
        chk("dflt.timeout", n, 21);
        step();
        set_valid = 1; set_ticks = 0;
        step();
        set_valid = 0;
        go = 1;
        step();
        go = 0;
        chk("zero.remaining", remaining, 600);
        do_reset();

`ifdef SNOOZE_EN
        // one snooze allowed, second press dismisses
        set_valid = 1; set_ticks = 1; go = 1;
        step();
        set_valid = 0; go = 0;
        wait_pulse(0, 10, n, other);
        chk("snz.first_start", n, 4);
        btn = 1;
        wait_pulse(1, 12, n, other);
        chk("snz.stop_lat", n, 7);
        btn = 0;
        chk("snz.busy", busy, 1);
        chk("snz.remaining", remaining, 2);
        wait_pulse(0, 12, n, other);
        chk("snz.restart_lat", n, 8);
        chk("snz.restart_stops", other, 0);
        btn = 1;
        wait_pulse(1, 12, n, other);
        chk("snz.dismiss_lat", n, 7);
        step();
        chk("snz.dismiss_busy", busy, 0);
        chk("snz.dismiss_stop", stop, 0);
        btn = 0;
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
